capture_counter: RTL and testbench
==================================

Name: capture_counter

Overview:
- Parametrised successor to the 64-bit free-running counter.
- Counts prescaled clock ticks and supports enable, load, and selectable wrap or saturate on terminal count with a sticky overflow flag.
- Provides CHANNELS independent timestamp-capture channels, each with a valid/ack handshake and lost-sample detection.
- Serves as the shared timebase and event-timestamp unit for software-visible timing measurement.

Parameters:
- DATA_WIDTH, 64: counter and capture register width.
- CHANNELS, 4: number of capture channels (1..32).
- PRESCALE_WIDTH, 16: width of the prescale input.
- SATURATE, 0: at all-ones, 0 = wrap to zero, 1 = hold at all-ones.

Ports:
- clk  in  1  : single clock, all logic on its rising edge.
- reset  in  1  : synchronous, active-high, full reset.
- reset_counter  in  1  : synchronous clear of counter, prescaler and overflow.
- enable  in  1  : count enable; prescaler and counter hold while low.
- load  in  1  : load counter from load_value.
- load_value  in  DATA_WIDTH  : value loaded on load.
- prescale  in  PRESCALE_WIDTH  : tick every prescale+1 enabled cycles.
- capture  in  CHANNELS  : per-channel capture strobe, sampled every cycle.
- capture_ack  in  CHANNELS  : per-channel consumer acknowledge.
- data  out  DATA_WIDTH (signed)  : live counter value.
- overflow  out  1  : sticky, set on terminal-count event.
- cap_valid  out  CHANNELS  : capture register holds an unacknowledged sample.
- cap_data  out  CHANNELS*DATA_WIDTH  : channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- cap_lost  out  CHANNELS  : sticky, an unacknowledged sample was overwritten.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: data=0, overflow=0, cap_valid=0, cap_data=0, cap_lost=0, internal prescaler pre_cnt=0. All registers also initialise to zero at configuration.
- Tick generation: tick = enable && (pre_cnt == prescale).
  - On tick, pre_cnt returns to 0.
  - Else, if enable, pre_cnt increments.
  - Else, pre_cnt holds.
  - prescale=0 gives a tick on every enabled cycle.
  - A prescale change mid-count takes effect on the next compare; if pre_cnt > prescale, pre_cnt counts up through wrap. This is accepted and not to be guarded.
- Counter priority per cycle, highest first:
  - reset
  - reset_counter: counter=0, pre_cnt=0, overflow=0.
  - load: counter=load_value, pre_cnt=0, overflow unchanged; a simultaneous tick is discarded.
  - tick: counter+1, computed modulo 2^DATA_WIDTH.
- Terminal count: a tick while counter is all-ones sets overflow=1 (sticky).
  - SATURATE=0: next counter value is 0.
  - SATURATE=1: counter holds at all-ones.
- Counter latency: data reflects a tick/load/clear one cycle after the causing cycle.
- Capture channel i, evaluated per cycle with v = cap_valid[i]:
  - capture[i]=1: cap_data[i] <= data as it appears in that cycle (pre-update value), and cap_valid[i] <= 1.
    - If v=1 and capture_ack[i]=0, set cap_lost[i]=1.
  - capture_ack[i]=1 and capture[i]=0: cap_valid[i] <= 0 and cap_lost[i] <= 0.
  - capture_ack[i]=1 and capture[i]=1: new sample stored, cap_valid stays 1, cap_lost cleared (the old sample counts as consumed).
  - capture_ack[i]=1 while v=0: no effect except clearing cap_lost.
  - A capture held high for N cycles yields N captures; only the last survives.
- Capture outputs update one cycle after the strobe.
- Captures are not affected by reset_counter, load or enable; only reset clears them.
- Channels are fully independent; simultaneous strobes on all channels capture the same value.

Decomposition:
- No shared package; the only constants are the parameter defaults above.
- One sub-module, capture_channel (DATA_WIDTH), holds a single channel's data/valid/lost registers and handshake.
- capture_counter instantiates capture_channel CHANNELS times via generate.
- The counter and prescaler stay in the top level.

Test Plan:
- Free-run: enable=1, prescale=0, DATA_WIDTH=64 → data = 0,1,2,... one per cycle after reset deasserts; prescale=2 → data increments every third cycle.
- Wrap and saturate: DATA_WIDTH=8, load 8'hFE, prescale=0.
  - SATURATE=0 → FE, FF, 00, overflow=1 from the 00 cycle onward.
  - SATURATE=1 → FE, FF, FF, overflow=1.
  - reset_counter then → data=0, overflow=0.
- Priority: load=1 and reset_counter=1 in the same cycle → data=0; load=1 with tick, load_value=100 → data=100, not 101.
- Capture handshake: with data=37 at the strobe, capture[1] pulse → next cycle cap_valid[1]=1, channel-1 slice=37; ack → cap_valid[1]=0; other channels unchanged.
- Lost sample: capture[0] at data=10, then at data=20 with no ack → cap_data=20, cap_lost[0]=1; a further capture+ack in the same cycle at data=30 → cap_data=30, cap_valid=1, cap_lost=0.
- Reset mid-operation: reset asserted while counting with valid captures pending → every output is 0 the following cycle; counting resumes from 0 after release.

Source files
------------

// File: rtl/capture_channel.sv
// Single timestamp-capture channel: holds one sample with a valid/ack
// handshake and a sticky flag for samples overwritten before acknowledge.
module capture_channel #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  capture_ack,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  cap_valid,
  output logic [DATA_WIDTH-1:0] cap_data,
  output logic                  cap_lost
);

  // A strobe always wins over ack for data/valid; ack always consumes the
  // old sample, so it clears the lost flag even when a new sample lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_lost  <= 1'b0;
    end else begin
      if (capture) begin
        cap_data  <= sample;
        cap_valid <= 1'b1;
      end else if (capture_ack) begin
        cap_valid <= 1'b0;
      end

      if (capture_ack) begin
        cap_lost <= 1'b0;
      end else if (capture && cap_valid) begin
        cap_lost <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/capture_counter.sv
// Prescaled timebase counter with load, wrap/saturate and sticky overflow,
// plus CHANNELS independent timestamp-capture channels.
module capture_counter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reset_counter,
  input  logic                           enable,
  input  logic                           load,
  input  logic [DATA_WIDTH-1:0]          load_value,
  input  logic [PRESCALE_WIDTH-1:0]      prescale,
  input  logic [CHANNELS-1:0]            capture,
  input  logic [CHANNELS-1:0]            capture_ack,
  output logic signed [DATA_WIDTH-1:0]   data,
  output logic                           overflow,
  output logic [CHANNELS-1:0]            cap_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] cap_data,
  output logic [CHANNELS-1:0]            cap_lost
);

  logic [DATA_WIDTH-1:0]     count_q;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      tick_c;

  // A prescale shrunk below pre_cnt is allowed to run through wrap.
  assign tick_c = enable && (pre_cnt == prescale);

  // Priority: reset, reset_counter, load (discards a coincident tick), tick.
  always_ff @(posedge clk) begin
    if (reset || reset_counter) begin
      count_q  <= '0;
      pre_cnt  <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      count_q <= load_value;
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
      if (&count_q) begin
        overflow <= 1'b1;
        count_q  <= SATURATE ? count_q : '0;
      end else begin
        count_q <= count_q + DATA_WIDTH'(1);
      end
    end else if (enable) begin
      pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
    end
  end

  assign data = $signed(count_q);

  // Every channel samples the pre-update counter value.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    capture_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture[i]),
      .capture_ack(capture_ack[i]),
      .sample     (count_q),
      .cap_valid  (cap_valid[i]),
      .cap_data   (cap_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .cap_lost   (cap_lost[i])
    );
  end

endmodule

// File: tb/tb_capture_counter.sv
// Scoreboard bench for capture_counter: a 64-bit wrap instance with four
// capture channels plus 8-bit wrap and saturate instances.
module tb_capture_counter;

  logic        clk = 1'b0;
  logic        reset, reset_counter, enable, load;
  logic [63:0] load_value;
  logic [15:0] prescale;
  logic [3:0]  capture, capture_ack;

  logic [63:0]  d64_data;
  logic         d64_ovf;
  logic [3:0]   d64_valid, d64_lost;
  logic [255:0] d64_cap;

  logic [7:0] d8w_data, d8s_data, d8w_cap, d8s_cap;
  logic       d8w_ovf, d8s_ovf, d8w_valid, d8s_valid, d8w_lost, d8s_lost;

  always #5 clk = ~clk;

  capture_counter #(.DATA_WIDTH(64), .CHANNELS(4), .PRESCALE_WIDTH(16), .SATURATE(1'b0)) dut64 (
    .clk(clk), .reset(reset), .reset_counter(reset_counter), .enable(enable), .load(load),
    .load_value(load_value), .prescale(prescale), .capture(capture), .capture_ack(capture_ack),
    .data(d64_data), .overflow(d64_ovf), .cap_valid(d64_valid), .cap_data(d64_cap), .cap_lost(d64_lost)
  );

  capture_counter #(.DATA_WIDTH(8), .CHANNELS(1), .PRESCALE_WIDTH(16), .SATURATE(1'b0)) dut8w (
    .clk(clk), .reset(reset), .reset_counter(reset_counter), .enable(enable), .load(load),
    .load_value(load_value[7:0]), .prescale(prescale), .capture(1'b0), .capture_ack(1'b0),
    .data(d8w_data), .overflow(d8w_ovf), .cap_valid(d8w_valid), .cap_data(d8w_cap), .cap_lost(d8w_lost)
  );

  capture_counter #(.DATA_WIDTH(8), .CHANNELS(1), .PRESCALE_WIDTH(16), .SATURATE(1'b1)) dut8s (
    .clk(clk), .reset(reset), .reset_counter(reset_counter), .enable(enable), .load(load),
    .load_value(load_value[7:0]), .prescale(prescale), .capture(1'b0), .capture_ack(1'b0),
    .data(d8s_data), .overflow(d8s_ovf), .cap_valid(d8s_valid), .cap_data(d8s_cap), .cap_lost(d8s_lost)
  );

  typedef enum int {
    S_DATA, S_OVF, S_VALID, S_CAP, S_LOST, S_W8, S_W8OVF, S_S8, S_S8OVF
  } sel_t;

  typedef struct {
    int unsigned cyc;
    sel_t        sel;
    int          ch;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] observe(sel_t sel, int ch);
    case (sel)
      S_DATA:  return d64_data;
      S_OVF:   return 64'(d64_ovf);
      S_VALID: return 64'(d64_valid);
      S_CAP:   return d64_cap[ch*64 +: 64];
      S_LOST:  return 64'(d64_lost);
      S_W8:    return 64'(d8w_data);
      S_W8OVF: return 64'(d8w_ovf);
      S_S8:    return 64'(d8s_data);
      default: return 64'(d8s_ovf);
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, away from the edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk_t        e;
      logic [63:0] act;
      e   = sb.pop_front();
      act = observe(e.sel, e.ch);
      n_checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d actual=%h required=%h", e.name, cyc, e.cyc, act, e.exp);
      end
    end
  end

  // Expectation for the state after the next rising edge.
  task automatic expect_nx(input sel_t sel, input int ch, input logic [63:0] v, input string name);
    chk_t e;
    e.cyc = cyc + 1; e.sel = sel; e.ch = ch; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] ps2_seq [6] = '{64'd4, 64'd4, 64'd5, 64'd5, 64'd5, 64'd6};

  initial begin
    reset = 1'b1; reset_counter = 1'b0; enable = 1'b0; load = 1'b0;
    load_value = '0; prescale = '0; capture = '0; capture_ack = '0;
    step(); step();

    // Reset state
    expect_nx(S_DATA, 0, 64'd0, "rst_data");
    expect_nx(S_OVF, 0, 64'd0, "rst_ovf");
    expect_nx(S_VALID, 0, 64'd0, "rst_valid");
    expect_nx(S_LOST, 0, 64'd0, "rst_lost");
    expect_nx(S_CAP, 2, 64'd0, "rst_cap2");
    step();

    // Free-run, prescale 0
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expect_nx(S_DATA, 0, 64'(i), "freerun");
      step();
    end

    // Prescale 2: one tick every third enabled cycle
    prescale = 16'd2;
    for (int i = 0; i < 6; i++) begin
      expect_nx(S_DATA, 0, ps2_seq[i], "prescale2");
      step();
    end

    // Disabled: hold
    enable = 1'b0;
    expect_nx(S_DATA, 0, 64'd6, "hold");
    step();
    expect_nx(S_DATA, 0, 64'd6, "hold");
    step();

    // Priority: reset_counter over load, then load over tick
    enable = 1'b1; prescale = 16'd0; load = 1'b1; load_value = 64'd100; reset_counter = 1'b1;
    expect_nx(S_DATA, 0, 64'd0, "rstcnt_over_load");
    step();
    reset_counter = 1'b0;
    expect_nx(S_DATA, 0, 64'd100, "load_over_tick");
    step();
    load = 1'b0;
    expect_nx(S_DATA, 0, 64'd101, "tick_after_load");
    step();

    // Capture handshake on channel 1 at data=37
    enable = 1'b0; load = 1'b1; load_value = 64'd37;
    expect_nx(S_DATA, 0, 64'd37, "load37");
    step();
    load = 1'b0; capture = 4'b0010;
    expect_nx(S_VALID, 0, 64'b0010, "cap1_valid");
    expect_nx(S_CAP, 1, 64'd37, "cap1_data");
    expect_nx(S_CAP, 0, 64'd0, "cap0_untouched");
    step();
    capture = 4'b0000; capture_ack = 4'b0010;
    expect_nx(S_VALID, 0, 64'b0000, "cap1_ack");
    expect_nx(S_CAP, 1, 64'd37, "cap1_data_kept");
    step();
    capture_ack = 4'b0000;

    // Lost sample on channel 0: captures at 10, 20 (no ack), 30 (with ack)
    load = 1'b1; load_value = 64'd10;
    expect_nx(S_DATA, 0, 64'd10, "load10");
    step();
    load_value = 64'd20; capture = 4'b0001;
    expect_nx(S_CAP, 0, 64'd10, "cap0_10");
    expect_nx(S_VALID, 0, 64'b0001, "cap0_valid");
    expect_nx(S_LOST, 0, 64'b0000, "cap0_not_lost");
    step();
    load_value = 64'd30;
    expect_nx(S_CAP, 0, 64'd20, "cap0_20");
    expect_nx(S_LOST, 0, 64'b0001, "cap0_lost");
    step();
    load = 1'b0; capture_ack = 4'b0001;
    expect_nx(S_CAP, 0, 64'd30, "cap0_30");
    expect_nx(S_VALID, 0, 64'b0001, "cap0_valid_ack");
    expect_nx(S_LOST, 0, 64'b0000, "cap0_lost_clr");
    step();
    capture = 4'b0000; capture_ack = 4'b0000;

    // 8-bit wrap vs saturate, then reset_counter
    enable = 1'b1; prescale = 16'd0; load = 1'b1; load_value = 64'hFE;
    expect_nx(S_W8, 0, 64'hFE, "w8_fe");
    expect_nx(S_S8, 0, 64'hFE, "s8_fe");
    step();
    load = 1'b0;
    expect_nx(S_W8, 0, 64'hFF, "w8_ff");
    expect_nx(S_W8OVF, 0, 64'd0, "w8_ovf0");
    expect_nx(S_S8, 0, 64'hFF, "s8_ff");
    expect_nx(S_S8OVF, 0, 64'd0, "s8_ovf0");
    step();
    expect_nx(S_W8, 0, 64'h00, "w8_wrap");
    expect_nx(S_W8OVF, 0, 64'd1, "w8_ovf1");
    expect_nx(S_S8, 0, 64'hFF, "s8_sat");
    expect_nx(S_S8OVF, 0, 64'd1, "s8_ovf1");
    step();
    expect_nx(S_W8, 0, 64'h01, "w8_after");
    expect_nx(S_W8OVF, 0, 64'd1, "w8_ovf_sticky");
    expect_nx(S_S8, 0, 64'hFF, "s8_hold");
    expect_nx(S_S8OVF, 0, 64'd1, "s8_ovf_sticky");
    step();
    reset_counter = 1'b1;
    expect_nx(S_W8, 0, 64'd0, "w8_rstcnt");
    expect_nx(S_W8OVF, 0, 64'd0, "w8_rstcnt_ovf");
    expect_nx(S_S8, 0, 64'd0, "s8_rstcnt");
    expect_nx(S_S8OVF, 0, 64'd0, "s8_rstcnt_ovf");
    step();
    reset_counter = 1'b0;

    // 64-bit terminal count
    load = 1'b1; load_value = '1;
    expect_nx(S_DATA, 0, 64'hFFFF_FFFF_FFFF_FFFF, "d64_allones");
    step();
    load = 1'b0;
    expect_nx(S_DATA, 0, 64'd0, "d64_wrap");
    expect_nx(S_OVF, 0, 64'd1, "d64_ovf");
    step();

    // Reset mid-operation with pending and lost captures
    capture = 4'b1111;
    expect_nx(S_VALID, 0, 64'b1111, "all_valid");
    step();
    expect_nx(S_LOST, 0, 64'b1111, "all_lost");
    expect_nx(S_CAP, 3, 64'd1, "cap3_same");
    expect_nx(S_CAP, 0, 64'd1, "cap0_same");
    step();
    capture = 4'b0000; reset = 1'b1;
    expect_nx(S_DATA, 0, 64'd0, "mid_rst_data");
    expect_nx(S_OVF, 0, 64'd0, "mid_rst_ovf");
    expect_nx(S_VALID, 0, 64'd0, "mid_rst_valid");
    expect_nx(S_LOST, 0, 64'd0, "mid_rst_lost");
    for (int i = 0; i < 4; i++) expect_nx(S_CAP, i, 64'd0, "mid_rst_cap");
    step();
    reset = 1'b0;
    expect_nx(S_DATA, 0, 64'd1, "resume1");
    step();
    expect_nx(S_DATA, 0, 64'd2, "resume2");
    step();

    step(); step();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
